// File: rtl/exhaustive_vector_checker_pkg.sv
// rtl/exhaustive_vector_checker_pkg.sv - shared types and constants for the exhaustive vector checker
package exhaustive_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;
  localparam int          HOLD_W            = 8;

endpackage

// File: rtl/exhaustive_vector_checker_if.sv
// rtl/exhaustive_vector_checker_if.sv - control, core-side and result signals of the vector checker
interface exhaustive_vector_checker_if #(
  parameter int N_IN   = 6,
  parameter int MISR_W = 16
);
  logic                start;
  logic                dut_out;
  logic [0:N_IN-1]     vec_out;
  logic                busy;
  logic                done;
  logic                pass;
  logic [N_IN:0]       mismatch_cnt;
  logic                first_fail_valid;
  logic [N_IN-1:0]     first_fail_vec;
  logic [MISR_W-1:0]   signature;

  modport master (
    output start, dut_out,
    input  vec_out, busy, done, pass, mismatch_cnt,
           first_fail_valid, first_fail_vec, signature
  );

  modport slave (
    input  start, dut_out,
    output vec_out, busy, done, pass, mismatch_cnt,
           first_fail_valid, first_fail_vec, signature
  );
endinterface

// File: rtl/exhaustive_vector_checker_sig_misr.sv
// rtl/exhaustive_vector_checker_sig_misr.sv - single-input signature register over sampled core outputs
module sig_misr
  import exhaustive_chk_pkg::*;
#(
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = MISR_POLY_DEFAULT
) (
  input  logic              CK,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              din,
  output logic [MISR_W-1:0] sig
);

  logic [MISR_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[MISR_W-2:0], 1'b0}
            ^ (sig_q[MISR_W-1] ? MISR_POLY : '0)
            ^ {{(MISR_W-1){1'b0}}, din};
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) sig_q <= '0;
    else       sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/exhaustive_vector_checker.sv
// rtl/exhaustive_vector_checker.sv - sweeps all input vectors, compares the core output to a golden table
module exhaustive_vector_checker
  import exhaustive_chk_pkg::*;
#(
  parameter int                   N_IN      = 6,
  parameter int                   HOLD      = 2,
  parameter logic [(1<<N_IN)-1:0] GOLDEN    = '0,
  parameter int                   MISR_W    = 16,
  parameter logic [MISR_W-1:0]    MISR_POLY = MISR_POLY_DEFAULT
) (
  input  logic                        CK,
  input  logic                        reset,
  exhaustive_vector_checker_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
  localparam logic [N_IN-1:0]   VEC_LAST  = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N_IN:0]     mis_q, mis_d;
  logic              ffv_q, ffv_d;
  logic [N_IN-1:0]   ffvec_q, ffvec_d;
  logic              accept, sample, last, miss;

  assign accept = bus.start && (state_q != RUN);
  assign sample = (state_q == RUN) && (hold_q == HOLD_LAST);
  assign last   = (vec_q == VEC_LAST);
  assign miss   = (bus.dut_out != GOLDEN[vec_q]);

  always_ff @(posedge CK or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start)      state_d = RUN;
      RUN:        if (sample && last) state_d = DONE;
      default:                        state_d = IDLE;
    endcase
  end

  // pass is only meaningful once done, so it is gated by the DONE state
  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.pass = (state_q == DONE) && (mis_q == '0);
  end

  always_comb begin
    vec_d   = vec_q;
    hold_d  = hold_q;
    mis_d   = mis_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (accept) begin
      vec_d   = '0;
      hold_d  = '0;
      mis_d   = '0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else if (state_q == RUN) begin
      if (!sample) begin
        hold_d = hold_q + HOLD_W'(1);
      end else begin
        hold_d = '0;
        // the final vector stays on vec_out after the sweep ends
        if (!last) vec_d = vec_q + N_IN'(1);
        if (miss) begin
          mis_d = mis_q + (N_IN+1)'(1);
          if (!ffv_q) begin
            ffv_d   = 1'b1;
            ffvec_d = vec_q;
          end
        end
      end
    end
  end

  always_ff @(posedge CK or posedge reset) begin
    if (reset) begin
      vec_q   <= '0;
      hold_q  <= '0;
      mis_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      mis_q   <= mis_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  sig_misr #(
    .MISR_W    (MISR_W),
    .MISR_POLY (MISR_POLY)
  ) u_misr (
    .CK    (CK),
    .reset (reset),
    .clr   (accept),
    .en    (sample),
    .din   (bus.dut_out),
    .sig   (bus.signature)
  );

  assign bus.vec_out          = vec_q;
  assign bus.mismatch_cnt     = mis_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;

endmodule
